// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the clk_50Mhz clock-enable generators.
package clock_div_pkg;

    localparam int          DIV_W_DEF = 32;
    localparam int          DIV_W_MAX = 64;
    localparam int unsigned MIN_DIV   = 2;

    // Divisors for common rates from a 50 MHz clock
    localparam int unsigned DIV_1MHZ  = 50;
    localparam int unsigned DIV_1KHZ  = 50_000;
    localparam int unsigned DIV_10HZ  = 5_000_000;
    localparam int unsigned DIV_5HZ   = 10_000_000;
    localparam int unsigned DIV_1HZ   = 50_000_000;

    typedef logic [DIV_W_MAX-1:0] div_wide_t;

    // Callers zero-extend into div_wide_t and truncate back, so any DIV_W up to 64 works.
    function automatic div_wide_t clamp_div(input div_wide_t div);
        return (div < div_wide_t'(MIN_DIV)) ? div_wide_t'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: period counter, glitch-free divisor update, tick and square-wave outputs.
module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DIV_5HZ
) (
    input  logic             clk_50Mhz,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] div_cur, div_cur_nxt;
    logic [DIV_W-1:0] div_pend, div_pend_nxt;
    logic             pend_nxt, tick_nxt, sq_nxt;
    logic             restart, wrap, apply;

    // A pending divisor is only ever applied while the counter restarts at 0,
    // so cnt never sits outside the new period and sq never glitches.
    assign restart = sync || !en;
    assign wrap    = !restart && (cnt == div_cur - DIV_W'(1));
    assign apply   = restart || wrap;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_nxt      = cnt + DIV_W'(1);
        tick_nxt     = wrap;
        sq_nxt       = !restart && (cnt >= (div_cur >> 1));
        div_cur_nxt  = div_cur;
        div_pend_nxt = div_pend;
        pend_nxt     = pend;

        if (apply) begin
            cnt_nxt  = '0;
            pend_nxt = 1'b0;
            if (pend) div_cur_nxt = div_pend;
        end

        // A write on an apply edge lands after the old value was consumed and stays pending.
        if (wr) begin
            div_pend_nxt = DIV_W'(clamp_div(div_wide_t'(wr_div)));
            pend_nxt     = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            cnt      <= '0;
            div_cur  <= DIV_W'(DEFAULT_DIV);
            // NOTE: div_pend is reset as well; it is a plain register, not a RAM, and must never be X.
            div_pend <= DIV_W'(DEFAULT_DIV);
            pend     <= 1'b0;
            tick     <= 1'b0;
            sq       <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_cur  <= div_cur_nxt;
            div_pend <= div_pend_nxt;
            pend     <= pend_nxt;
            tick     <= tick_nxt;
            sq       <= sq_nxt;
        end
    end

endmodule

// File: rtl/clock_enable_gen.sv
// NUM_CH parallel clock-enable channels in the clk_50Mhz domain with run-time divisors and a global phase sync.
module clock_enable_gen
    import clock_div_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DIV_5HZ,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_50Mhz,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] pend
);

    // One extra bit so NUM_CH itself is representable when it is a power of two.
    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    logic wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < NUM_CH_L);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_ok && (wr_ch == CH_W'(i));

        clock_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_50Mhz (clk_50Mhz),
            .rst       (rst),
            .en        (ch_en[i]),
            .sync      (sync),
            .wr        (wr_sel),
            .wr_div    (wr_div),
            .tick      (tick[i]),
            .sq        (sq[i]),
            .pend      (pend[i])
        );
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen: directed vector table, corner sequences, randomized run vs. a period model.
module tb_clock_enable_gen;

    localparam int NCH  = 3;
    localparam int DW   = 32;
    localparam int CW   = 2;
    localparam int DEFD = 4;

    logic           clk_50Mhz = 1'b0;
    logic           rst       = 1'b1;
    logic [NCH-1:0] ch_en     = '0;
    logic           sync      = 1'b0;
    logic           wr_en     = 1'b0;
    logic [CW-1:0]  wr_ch     = '0;
    logic [DW-1:0]  wr_div    = '0;
    logic [NCH-1:0] tick, sq, pend;

    clock_enable_gen #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEFD)
    ) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .tick      (tick),
        .sq        (sq),
        .pend      (pend)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: each channel counts edges completed within the current period.
    int unsigned    m_done [NCH];
    int unsigned    m_div  [NCH];
    int unsigned    m_next [NCH];
    bit             m_has  [NCH];
    logic [NCH-1:0] m_tick, m_sq, m_pend;

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit period_start;
            if (rst) begin
                m_done[c] = 0; m_div[c] = DEFD; m_has[c] = 0;
                m_tick[c] = 0; m_sq[c] = 0;
                continue;
            end
            period_start = 0;
            if (sync || !ch_en[c]) begin
                m_done[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
                period_start = 1;
            end else begin
                int unsigned pos;
                pos = m_done[c] + 1;
                m_tick[c] = (pos == m_div[c]);
                m_sq[c]   = (pos > m_div[c] / 2);
                if (pos == m_div[c]) begin
                    m_done[c] = 0;
                    period_start = 1;
                end else begin
                    m_done[c] = pos;
                end
            end
            if (period_start && m_has[c]) begin
                m_div[c] = m_next[c];
                m_has[c] = 0;
            end
            if (wr_en && int'(wr_ch) == c) begin
                m_next[c] = (wr_div < 2) ? 2 : int'(wr_div);
                m_has[c]  = 1;
            end
        end
        for (int c = 0; c < NCH; c++) m_pend[c] = m_has[c];
    endtask

    task automatic step();
        @(posedge clk_50Mhz);
        model_edge();
        #1;
        check("tick_model", 32'(tick), 32'(m_tick));
        check("sq_model",   32'(sq),   32'(m_sq));
        check("pend_model", 32'(pend), 32'(m_pend));
    endtask

    task automatic write(input int ch, input int unsigned div);
        wr_en = 1'b1; wr_ch = CW'(ch); wr_div = DW'(div);
        step();
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic           rst;
        logic [NCH-1:0] ch_en;
        logic           wr_en;
        logic [CW-1:0]  wr_ch;
        logic [DW-1:0]  wr_div;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] exp_sq;
        logic [NCH-1:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic [NCH-1:0] en, input logic w,
                           input int ch, input int unsigned div,
                           input logic [NCH-1:0] t, input logic [NCH-1:0] s, input logic [NCH-1:0] p);
        vec_t v;
        v.rst = r; v.ch_en = en; v.wr_en = w; v.wr_ch = CW'(ch); v.wr_div = DW'(div);
        v.exp_tick = t; v.exp_sq = s; v.exp_pend = p;
        vecs.push_back(v);
    endtask

    initial begin
        int cnt0, cnt1, found;

        // Reset, then divide-by-4 on all channels; write ch0 div=5 when its cnt is 1.
        add_vec(1, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b111, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b111, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 1, 0, 5, 3'b000, 3'b000, 3'b001);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b001);
        add_vec(0, 3'b111, 0, 0, 0, 3'b111, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b110, 3'b111, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b001, 3'b001, 3'b000);
        add_vec(0, 3'b111, 0, 0, 0, 3'b000, 3'b000, 3'b000);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; ch_en = vecs[i].ch_en;
            wr_en = vecs[i].wr_en; wr_ch = vecs[i].wr_ch; wr_div = vecs[i].wr_div;
            step();
            check($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            check($sformatf("vec%0d_sq",   i), 32'(sq),   32'(vecs[i].exp_sq));
            check($sformatf("vec%0d_pend", i), 32'(pend), 32'(vecs[i].exp_pend));
        end
        wr_en = 1'b0;

        // Divisors 1 and 0 clamp to 2: tick every other cycle.
        write(0, 1);
        write(1, 0);
        repeat (10) step();
        cnt0 = 0; cnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            cnt0 += int'(tick[0]);
            cnt1 += int'(tick[1]);
            check("clamp_sq_toggle", 32'(sq[0]), 32'(k % 2 == 0 ? !sq[0] : sq[0]) ^ 32'(k % 2 == 0));
        end
        check("clamp_ticks_ch0", 32'(cnt0), 32'd4);
        check("clamp_ticks_ch1", 32'(cnt1), 32'd4);

        // Out-of-range channel index is ignored.
        write(3, 7);
        check("bad_ch_pend", 32'(pend), 32'd0);
        repeat (4) step();

        // Back to div 4 everywhere, aligned by a sync, then sync on a ch1 wrap.
        write(0, 4); write(1, 4); write(2, 4);
        sync = 1'b1; step(); sync = 1'b0;
        check("sync_apply_pend", 32'(pend), 32'd0);
        repeat (2) step();
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_done[1] == m_div[1] - 1) found = 1;
            else step();
        end
        check("sync_wrap_found", 32'(found), 32'd1);
        sync = 1'b1; step(); sync = 1'b0;
        check("sync_no_tick", 32'(tick), 32'd0);
        check("sync_sq_low",  32'(sq),   32'd0);
        repeat (3) step();
        check("sync_pre_tick", 32'(tick), 32'd0);
        step();
        check("sync_aligned_tick", 32'(tick), 32'b111);

        // Disable ch0 mid-period with a write pending, then re-enable.
        step();
        write(0, 3);
        check("dis_pend_set", 32'(pend[0]), 32'd1);
        ch_en = 3'b110;
        step();
        check("dis_pend_applied", 32'(pend[0]), 32'd0);
        check("dis_tick0", 32'(tick[0]), 32'd0);
        check("dis_sq0",   32'(sq[0]),   32'd0);
        repeat (3) step();
        ch_en = 3'b111;
        repeat (2) step();
        check("reen_no_tick", 32'(tick[0]), 32'd0);
        step();
        check("reen_first_tick", 32'(tick[0]), 32'd1);

        // Randomized run against the model.
        for (int k = 0; k < 400; k++) begin
            rst    = ($urandom_range(0, 99) == 0);
            sync   = ($urandom_range(0, 39) == 0);
            ch_en  = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : 3'b111;
            wr_en  = ($urandom_range(0, 5) == 0);
            wr_ch  = CW'($urandom_range(0, 3));
            wr_div = DW'($urandom_range(0, 7));
            step();
        end
        rst = 1'b0; sync = 1'b0; wr_en = 1'b0;

        // Reset mid-period abandons the period.
        ch_en = 3'b111;
        repeat (2) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_sq",   32'(sq),   32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
